boot_verifier: RTL and testbench
================================

Name: boot_verifier

Overview:
- Read-back checker for the boot path.
- After the bootloader has copied the boot ROM into instruction memory, this block re-reads both the ROM and the instruction memory word by word and compares them.
- Reports pass/fail, a saturating mismatch count and details of the first mismatch.
- Sits alongside the bootloader on the clk_div8 domain. Its memory-read port is muxed into the SRAM path in place of the processor instruction port.

Parameters:
DATA_WIDTH, 32, width of ROM and memory words
ADDR_WIDTH, 20, word address width for both ROM and instruction memory
WORD_COUNT, 1024, number of words checked, starting at address 0; legal range 1..2^ADDR_WIDTH
ERR_CNT_WIDTH, 16, width of mismatch counter

Ports:
clk  input  1  block clock (clk_div8 domain)
rst_n  input  1  asynchronous active-low reset
start  input  1  single-cycle pulse; starts a verify pass
rom_rd_en  output  1  boot ROM read strobe
rom_addr  output  ADDR_WIDTH  boot ROM word address
rom_rd_data  input  DATA_WIDTH  boot ROM data, valid the cycle after rom_rd_en
mem_rd_en  output  1  instruction memory read strobe
mem_addr  output  ADDR_WIDTH  instruction memory word address
mem_rd_data  input  DATA_WIDTH  instruction memory data, valid the cycle after mem_rd_en
busy  output  1  high while a pass is running
done  output  1  high in DONE state until the next start
pass  output  1  valid while done=1; 1 when err_count==0
err_count  output  ERR_CNT_WIDTH  mismatches in the current/last pass, saturating
first_err_addr  output  ADDR_WIDTH  address of the first mismatch
first_err_rom_data  output  DATA_WIDTH  ROM word at the first mismatch
first_err_mem_data  output  DATA_WIDTH  memory word at the first mismatch

Behaviour:
- Reset (async assert, synchronous release):
  - state=IDLE.
  - All outputs 0.
  - Address pointer 0 and internal first-error flag cleared.
- States: IDLE, READ, CMP, DONE.
- IDLE:
  - busy=0, done=0.
  - start=1 -> clear err_count, first_err_* and pointer; go to READ.
- READ (one cycle):
  - rom_rd_en=1, mem_rd_en=1.
  - rom_addr=mem_addr=pointer.
  - busy=1. Next state CMP.
- CMP (one cycle):
  - Read enables 0. Addresses hold the pointer value.
  - Sample rom_rd_data and mem_rd_data and compare them.
  - On mismatch:
    - err_count increments; holds at all-ones, no wrap.
    - If this is the first mismatch of the pass, latch first_err_addr=pointer and both data words.
  - If pointer==WORD_COUNT-1 -> DONE; else pointer+1 -> READ.
- Throughput and latency:
  - Exactly 2 cycles per word.
  - A pass takes 2*WORD_COUNT cycles from the cycle after start to done rising.
- DONE:
  - busy=0, done=1, pass=(err_count==0).
  - Results hold until start.
  - start=1 in DONE behaves as in IDLE: clears results, done drops the next cycle, new pass begins.
- Boundary conditions:
  - start while busy: ignored; the pass continues unaffected.
  - start coincident with the last CMP: ignored; block enters DONE.
  - Pointer wrap: with WORD_COUNT=2^ADDR_WIDTH the final compare is at all-ones address. The pointer must not wrap before DONE. Use an ADDR_WIDTH+1 comparison or a last-word flag.
  - rst_n asserted mid-pass: immediate return to IDLE with all outputs 0; no partial results retained.
  - Read enables are never asserted outside READ, so the block can share the SRAM mux with no side effects when idle.
  - Data comparison is full-width equality; no masking.

Test Plan:
- Clean compare: WORD_COUNT=8, ROM and memory models hold identical words 0x1000_0000+addr; pulse start -> busy for 16 cycles; done=1, pass=1, err_count=0, first_err_* =0.
- Single mismatch: memory word 5 = 0xDEADBEEF, ROM word 5 = 0x1000_0005 -> done=1, pass=0, err_count=1, first_err_addr=5, first_err_rom_data=0x1000_0005, first_err_mem_data=0xDEADBEEF.
- Multiple mismatches and first-error latch: mismatches at addresses 2, 3, 7 -> err_count=3, first_err_addr=2; details at 3 and 7 do not overwrite it.
- Saturation: ERR_CNT_WIDTH=2, all 8 words differ -> err_count=3, pass=0.
- Start handling:
  - Start pulses at cycles 4 and 9 mid-pass are ignored; done still rises after 16 cycles.
  - A start in DONE clears err_count and done within 1 cycle and reruns the pass.
- Reset mid-pass: assert rst_n=0 at cycle 7 -> all outputs 0 immediately; after release with no start, the block stays IDLE with read enables at 0.

Source files
------------

// File: rtl/boot_verifier.sv
// boot_verifier: re-reads boot ROM and instruction memory word by word after boot copy,
// reporting pass/fail, a saturating mismatch count and the first mismatch details.
module boot_verifier #(
    parameter int DATA_WIDTH    = 32,
    parameter int ADDR_WIDTH    = 20,
    parameter int WORD_COUNT    = 1024,
    parameter int ERR_CNT_WIDTH = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     start,
    output logic                     rom_rd_en,
    output logic [ADDR_WIDTH-1:0]    rom_addr,
    input  logic [DATA_WIDTH-1:0]    rom_rd_data,
    output logic                     mem_rd_en,
    output logic [ADDR_WIDTH-1:0]    mem_addr,
    input  logic [DATA_WIDTH-1:0]    mem_rd_data,
    output logic                     busy,
    output logic                     done,
    output logic                     pass,
    output logic [ERR_CNT_WIDTH-1:0] err_count,
    output logic [ADDR_WIDTH-1:0]    first_err_addr,
    output logic [DATA_WIDTH-1:0]    first_err_rom_data,
    output logic [DATA_WIDTH-1:0]    first_err_mem_data
);
    typedef enum logic [1:0] {IDLE, READ, CMP, DONE} state_t;
    // Last-word compare stops the pointer before it could wrap at WORD_COUNT == 2^ADDR_WIDTH.
    localparam logic [ADDR_WIDTH-1:0] LAST = ADDR_WIDTH'(WORD_COUNT - 1);
    state_t                   state;
    logic [ADDR_WIDTH-1:0]    ptr;
    logic                     rd_en;
    logic                     first_seen;
    logic                     mismatch;
    logic [ERR_CNT_WIDTH-1:0] err_next;
    assign mismatch  = rom_rd_data != mem_rd_data;
    assign err_next  = (mismatch && !(&err_count)) ? err_count + 1'b1 : err_count;
    assign rom_addr  = ptr;
    assign mem_addr  = ptr;
    assign rom_rd_en = rd_en;
    assign mem_rd_en = rd_en;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state              <= IDLE;
            ptr                <= '0;
            rd_en              <= 1'b0;
            first_seen         <= 1'b0;
            busy               <= 1'b0;
            done               <= 1'b0;
            pass               <= 1'b0;
            err_count          <= '0;
            first_err_addr     <= '0;
            first_err_rom_data <= '0;
            first_err_mem_data <= '0;
        end else begin
            case (state)
                IDLE, DONE: if (start) begin
                    state              <= READ;
                    ptr                <= '0;
                    rd_en              <= 1'b1;
                    first_seen         <= 1'b0;
                    busy               <= 1'b1;
                    done               <= 1'b0;
                    pass               <= 1'b0;
                    err_count          <= '0;
                    first_err_addr     <= '0;
                    first_err_rom_data <= '0;
                    first_err_mem_data <= '0;
                end
                READ: begin
                    state <= CMP;
                    rd_en <= 1'b0;
                end
                CMP: begin
                    err_count <= err_next;
                    if (mismatch && !first_seen) begin
                        first_seen         <= 1'b1;
                        first_err_addr     <= ptr;
                        first_err_rom_data <= rom_rd_data;
                        first_err_mem_data <= mem_rd_data;
                    end
                    if (ptr == LAST) begin
                        state <= DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        pass  <= err_next == '0;
                    end else begin
                        state <= READ;
                        ptr   <= ptr + 1'b1;
                        rd_en <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_boot_verifier.sv
// tb_boot_verifier: randomized passes against a cycle-count/prefix-compare model of the verifier.
module tb_boot_verifier;
    localparam int DW = 32, AW = 3, W = 8, EW = 2;
    localparam int SAT = (1 << EW) - 1;
    logic clk = 0, rst_n = 0, start = 0;
    logic rom_rd_en, mem_rd_en, busy, done, pass;
    logic [AW-1:0] rom_addr, mem_addr, first_err_addr;
    logic [DW-1:0] rom_rd_data = 0, mem_rd_data = 0, first_err_rom_data, first_err_mem_data;
    logic [EW-1:0] err_count;
    logic [DW-1:0] rom [W], mem [W], srom [W], smem [W];
    int total = 0, bad = 0;
    int cyc = 0;
    bit done_m = 0;
    int bc;

    boot_verifier #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .WORD_COUNT(W), .ERR_CNT_WIDTH(EW)) dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .rom_rd_en(rom_rd_en), .rom_addr(rom_addr), .rom_rd_data(rom_rd_data),
        .mem_rd_en(mem_rd_en), .mem_addr(mem_addr), .mem_rd_data(mem_rd_data),
        .busy(busy), .done(done), .pass(pass), .err_count(err_count),
        .first_err_addr(first_err_addr), .first_err_rom_data(first_err_rom_data),
        .first_err_mem_data(first_err_mem_data)
    );

    always #5 clk = ~clk;

    // Memories return garbage when not read so mistimed sampling shows up.
    always @(posedge clk) begin
        rom_rd_data <= rom_rd_en ? rom[rom_addr] : $urandom;
        mem_rd_data <= mem_rd_en ? mem[mem_addr] : $urandom;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_prefix(input int n, output int cnt, output int fa,
                                output logic [DW-1:0] fr, output logic [DW-1:0] fm);
        cnt = 0; fa = 0; fr = 0; fm = 0;
        for (int i = 0; i < n; i++)
            if (srom[i] !== smem[i]) begin
                if (cnt == 0) begin fa = i; fr = srom[i]; fm = smem[i]; end
                cnt++;
            end
    endtask

    // Model: cyc counts cycles 1..2W of a pass; word k is read at cycle 2k+1.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cyc = 0; done_m = 0;
        end else if (cyc >= 1 && cyc < 2 * W) cyc++;
        else if (cyc == 2 * W) begin cyc = 0; done_m = 1; end
        else if (start) begin
            cyc = 1; done_m = 0;
            for (int i = 0; i < W; i++) begin srom[i] = rom[i]; smem[i] = mem[i]; end
        end
    end

    always @(negedge clk) if (rst_n) begin
        int n, cnt, fa;
        logic [DW-1:0] fr, fm;
        bit b;
        b = cyc != 0;
        n = b ? (cyc - 1) / 2 : (done_m ? W : 0);
        model_prefix(n, cnt, fa, fr, fm);
        check("busy", 64'(busy), 64'(b));
        check("done", 64'(done), 64'(done_m));
        check("rom_rd_en", 64'(rom_rd_en), 64'(b && cyc % 2 == 1));
        check("mem_rd_en", 64'(mem_rd_en), 64'(b && cyc % 2 == 1));
        if (b || !done_m) begin
            check("rom_addr", 64'(rom_addr), 64'(b ? (cyc - 1) / 2 : 0));
            check("mem_addr", 64'(mem_addr), 64'(b ? (cyc - 1) / 2 : 0));
        end
        check("pass", 64'(pass), 64'(done_m && cnt == 0));
        check("err_count", 64'(err_count), 64'(cnt > SAT ? SAT : cnt));
        check("first_err_addr", 64'(first_err_addr), 64'(fa));
        check("first_err_rom_data", 64'(first_err_rom_data), 64'(fr));
        check("first_err_mem_data", 64'(first_err_mem_data), 64'(fm));
    end

    task automatic set_words(input logic [W-1:0] diff);
        for (int i = 0; i < W; i++) begin
            rom[i] = 32'h1000_0000 + DW'(i);
            mem[i] = diff[i] ? ~rom[i] : rom[i];
        end
    endtask

    task automatic wait_done(input logic [63:0] mask, output int cycles);
        cycles = 0;
        for (int i = 1; i < 100 && !done; i++) begin
            if (busy) cycles++;
            start = mask[i];
            @(negedge clk);
        end
        start = 0;
        if (!done) check("done_timeout", 64'(done), 64'(1));
    endtask

    task automatic do_pass(input logic [63:0] mask, output int cycles);
        start = 1;
        @(negedge clk);
        start = 0;
        wait_done(mask, cycles);
    endtask

    initial begin
        set_words('0);
        repeat (3) @(negedge clk);
        rst_n = 1;
        repeat (2) @(negedge clk);
        check("idle_busy", 64'(busy), 64'(0));
        check("idle_rd_en", 64'(rom_rd_en | mem_rd_en), 64'(0));
        do_pass('0, bc);
        check("clean_cycles", 64'(bc), 64'(16));
        check("clean_pass", 64'(pass), 64'(1));
        check("clean_err", 64'(err_count), 64'(0));
        set_words('0);
        mem[5] = 32'hDEAD_BEEF;
        do_pass('0, bc);
        check("single_pass", 64'(pass), 64'(0));
        check("single_err", 64'(err_count), 64'(1));
        check("single_addr", 64'(first_err_addr), 64'(5));
        check("single_rom", 64'(first_err_rom_data), 64'(32'h1000_0005));
        check("single_mem", 64'(first_err_mem_data), 64'(32'hDEAD_BEEF));
        set_words(8'b1000_1100);
        do_pass('0, bc);
        check("multi_err", 64'(err_count), 64'(3));
        check("multi_addr", 64'(first_err_addr), 64'(2));
        check("multi_mem", 64'(first_err_mem_data), 64'(32'hEFFF_FFFD));
        set_words(8'hFF);
        do_pass('0, bc);
        check("sat_err", 64'(err_count), 64'(3));
        check("sat_pass", 64'(pass), 64'(0));
        set_words('0);
        do_pass(64'h1_0210, bc);
        check("busy_start_cycles", 64'(bc), 64'(16));
        check("busy_start_pass", 64'(pass), 64'(1));
        set_words(8'h01);
        do_pass('0, bc);
        set_words('0);
        start = 1;
        @(negedge clk);
        start = 0;
        check("rerun_done_drop", 64'(done), 64'(0));
        check("rerun_err_clear", 64'(err_count), 64'(0));
        check("rerun_busy", 64'(busy), 64'(1));
        wait_done('0, bc);
        check("rerun_cycles", 64'(bc), 64'(16));
        check("rerun_pass", 64'(pass), 64'(1));
        set_words(8'h10);
        start = 1;
        @(negedge clk);
        start = 0;
        repeat (6) @(negedge clk);
        #2 rst_n = 0;
        #1;
        check("rst_busy", 64'(busy), 64'(0));
        check("rst_rd_en", 64'(rom_rd_en | mem_rd_en), 64'(0));
        check("rst_addr", 64'(rom_addr | mem_addr), 64'(0));
        check("rst_results", 64'(done | pass | (|err_count) | (|first_err_addr)), 64'(0));
        check("rst_data", 64'(first_err_rom_data | first_err_mem_data), 64'(0));
        @(negedge clk);
        rst_n = 1;
        repeat (5) @(negedge clk);
        check("post_rst_idle", 64'(busy | done), 64'(0));
        check("post_rst_rd_en", 64'(rom_rd_en | mem_rd_en), 64'(0));
        repeat (20) begin
            for (int i = 0; i < W; i++) begin
                rom[i] = $urandom;
                mem[i] = ($urandom_range(0, 2) == 0) ? rom[i] ^ (32'h1 << $urandom_range(0, 31)) : rom[i];
            end
            do_pass({$urandom, $urandom}, bc);
            check("rand_cycles", 64'(bc), 64'(16));
            repeat ($urandom_range(0, 3)) @(negedge clk);
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
